// File: rtl/sa_arb_pkg.sv
// Shared state encoding and sizing helpers for the systolic-array arbiter.
package sa_arb_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, START, BUSY, DONE, ABORT} state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slot_width(input int rows, input int cols, input int dw);
        return rows * cols * dw;
    endfunction

endpackage

// File: rtl/sa_rr_picker.sv
// Combinational round-robin picker: the first pending bit after rr_ptr wins,
// wrapping modulo N_REQ.
module sa_rr_picker
    import sa_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (!win_vld && pending[cand]) begin
                win_vld      = 1'b1;
                win_idx      = cand;
                win_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_arbiter.sv
// Round-robin sharing of one SA_wrapper between N_REQ matrix-multiply requesters.
// Define SA_ARB_TIMEOUT_EN to build the BUSY watchdog that raises O_ERR.
module sa_arbiter
    import sa_arb_pkg::*;
#(
    parameter int D_W         = 16,
    parameter int SA_R        = 16,
    parameter int SA_C        = 16,
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                I_CLK,
    input  logic                                I_ASYN_RSTN,
    input  logic                                I_SYNC_RSTN,
    input  logic [N_REQ-1:0]                    I_REQ,
    input  logic [N_REQ*SA_R*SA_C*D_W-1:0]      I_MAT_1,
    input  logic [N_REQ*SA_R*SA_C*D_W-1:0]      I_MAT_2,
    output logic [N_REQ-1:0]                    O_GNT,
    output logic [N_REQ-1:0]                    O_DONE,
    output logic [SA_R*SA_C*D_W-1:0]            O_RESULT,
    output logic [N_REQ-1:0]                    O_PE_SHIFT,
    output logic [N_REQ-1:0]                    O_ERR,
    output logic                                O_SA_START,
    output logic                                O_SA_CLEARN,
    output logic [SA_R*SA_C*D_W-1:0]            O_MAT_1,
    output logic [SA_R*SA_C*D_W-1:0]            O_MAT_2,
    input  logic                                I_SA_VLD,
    input  logic                                I_PE_SHIFT,
    input  logic [SA_R*SA_C*D_W-1:0]            I_SA_RESULT
);

    localparam int M     = slot_width(SA_R, SA_C, D_W);
    localparam int IDX_W = idx_width(N_REQ);

    state_t           state;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] grant_clr;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;

    sa_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign grant_clr = (state == IDLE && win_vld) ? win_oh : '0;

`ifdef SA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] busy_cnt;
`else
    // Watchdog not built; this reads as a constant zero.
    assign O_ERR = {N_REQ{TIMEOUT_CYC < 0}};
`endif

    // Control FSM; the sync clear mirrors the async reset exactly.
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state       <= IDLE;
            pending     <= '0;
            rr_ptr      <= IDX_W'(N_REQ - 1);
            gnt_idx     <= '0;
            O_GNT       <= '0;
            O_DONE      <= '0;
            O_RESULT    <= '0;
            O_SA_START  <= 1'b0;
            O_SA_CLEARN <= 1'b1;
`ifdef SA_ARB_TIMEOUT_EN
            O_ERR       <= '0;
            busy_cnt    <= '0;
`endif
        end else if (!I_SYNC_RSTN) begin
            state       <= IDLE;
            pending     <= '0;
            rr_ptr      <= IDX_W'(N_REQ - 1);
            gnt_idx     <= '0;
            O_GNT       <= '0;
            O_DONE      <= '0;
            O_RESULT    <= '0;
            O_SA_START  <= 1'b0;
            O_SA_CLEARN <= 1'b1;
`ifdef SA_ARB_TIMEOUT_EN
            O_ERR       <= '0;
            busy_cnt    <= '0;
`endif
        end else begin
            O_DONE      <= '0;
            O_SA_START  <= 1'b0;
            O_SA_CLEARN <= 1'b1;
`ifdef SA_ARB_TIMEOUT_EN
            O_ERR       <= '0;
`endif
            // A new request on the granting edge re-arms the bit it would clear.
            pending <= (pending & ~grant_clr) | I_REQ;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        O_GNT   <= win_oh;
                        gnt_idx <= win_idx;
                        rr_ptr  <= win_idx;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    O_SA_CLEARN <= 1'b0;
                    state       <= START;
                end
                START: begin
                    O_SA_START <= 1'b1;
                    state      <= BUSY;
`ifdef SA_ARB_TIMEOUT_EN
                    busy_cnt   <= '0;
`endif
                end
                BUSY: begin
                    if (I_SA_VLD) begin
                        O_RESULT <= I_SA_RESULT;
                        O_DONE   <= O_GNT;
                        state    <= DONE;
                    end
`ifdef SA_ARB_TIMEOUT_EN
                    else if (busy_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        O_ERR <= O_GNT;
                        state <= ABORT;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    O_GNT <= '0;
                    state <= IDLE;
                end
                ABORT: begin
                    O_SA_CLEARN <= 1'b0;
                    O_GNT       <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand buses follow the granted slot and rest at zero between jobs.
    always_comb begin
        O_MAT_1 = '0;
        O_MAT_2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (|O_GNT && gnt_idx == IDX_W'(i)) begin
                O_MAT_1 = I_MAT_1[i*M +: M];
                O_MAT_2 = I_MAT_2[i*M +: M];
            end
        end
    end

    assign O_PE_SHIFT = {N_REQ{I_PE_SHIFT}} & O_GNT;

endmodule

// File: tb/tb_sa_arbiter.sv
// Scoreboard bench for sa_arbiter with a behavioural SA stub (lane-wise add, fixed latency).
module tb_sa_arbiter;

    localparam int D_W         = 16;
    localparam int SA_R        = 16;
    localparam int SA_C        = 16;
    localparam int N_REQ       = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int M           = SA_R * SA_C * D_W;
    localparam int SA_LAT      = 20;

    logic                    I_CLK;
    logic                    I_ASYN_RSTN;
    logic                    I_SYNC_RSTN;
    logic [N_REQ-1:0]        I_REQ;
    logic [N_REQ*M-1:0]      I_MAT_1;
    logic [N_REQ*M-1:0]      I_MAT_2;
    logic [N_REQ-1:0]        O_GNT;
    logic [N_REQ-1:0]        O_DONE;
    logic [M-1:0]            O_RESULT;
    logic [N_REQ-1:0]        O_PE_SHIFT;
    logic [N_REQ-1:0]        O_ERR;
    logic                    O_SA_START;
    logic                    O_SA_CLEARN;
    logic [M-1:0]            O_MAT_1;
    logic [M-1:0]            O_MAT_2;
    logic                    I_SA_VLD;
    logic                    I_PE_SHIFT;
    logic [M-1:0]            I_SA_RESULT;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int           id;
        logic [M-1:0] res;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    sa_arbiter #(
        .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .I_CLK       (I_CLK),
        .I_ASYN_RSTN (I_ASYN_RSTN),
        .I_SYNC_RSTN (I_SYNC_RSTN),
        .I_REQ       (I_REQ),
        .I_MAT_1     (I_MAT_1),
        .I_MAT_2     (I_MAT_2),
        .O_GNT       (O_GNT),
        .O_DONE      (O_DONE),
        .O_RESULT    (O_RESULT),
        .O_PE_SHIFT  (O_PE_SHIFT),
        .O_ERR       (O_ERR),
        .O_SA_START  (O_SA_START),
        .O_SA_CLEARN (O_SA_CLEARN),
        .O_MAT_1     (O_MAT_1),
        .O_MAT_2     (O_MAT_2),
        .I_SA_VLD    (I_SA_VLD),
        .I_PE_SHIFT  (I_PE_SHIFT),
        .I_SA_RESULT (I_SA_RESULT)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    // SA stub: latches the lane-wise sum at START, answers SA_LAT cycles later.
    logic [7:0]   sa_cnt;
    logic         sa_vld_r;
    logic         spur_vld;
    logic         stub_dead;
    logic [M-1:0] sa_res;

    function automatic logic [M-1:0] lane_sum(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < SA_R * SA_C; i++) r[i*D_W +: D_W] = a[i*D_W +: D_W] + b[i*D_W +: D_W];
        return r;
    endfunction

    always @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            sa_cnt   <= '0;
            sa_vld_r <= 1'b0;
            sa_res   <= '0;
        end else begin
            sa_vld_r <= 1'b0;
            if (O_SA_START && !stub_dead) begin
                sa_cnt <= 8'(SA_LAT);
                sa_res <= lane_sum(O_MAT_1, O_MAT_2);
            end else if (sa_cnt != 0) begin
                sa_cnt <= sa_cnt - 8'd1;
                if (sa_cnt == 8'd1) sa_vld_r <= 1'b1;
            end
        end
    end

    assign I_SA_VLD    = sa_vld_r | spur_vld;
    assign I_PE_SHIFT  = (sa_cnt != 0);
    assign I_SA_RESULT = sa_vld_r ? sa_res : {M{1'b1}};

    // Operand pattern: row r holds 0x100*r, tagged by requester so slots differ.
    function automatic logic [M-1:0] op1(input int id);
        logic [M-1:0] v;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) v[(r*SA_C+c)*D_W +: D_W] = 16'(16'h100 * r + id);
        return v;
    endfunction

    function automatic logic [M-1:0] op2(input int id);
        logic [M-1:0] v;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) v[(r*SA_C+c)*D_W +: D_W] = 16'(16'h100 * r + 16'h10 * id);
        return v;
    endfunction

    function automatic logic [M-1:0] golden(input int id);
        logic [M-1:0] v;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) v[(r*SA_C+c)*D_W +: D_W] = 16'(16'h200 * r + 16'h11 * id);
        return v;
    endfunction

    task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_wide(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got low64 %h, expected low64 %h at %0t", nm, act[63:0], exp[63:0], $time);
        end
    endtask

    task automatic expect_job(input int id);
        exp_q.push_back('{id, golden(id)});
    endtask

    // Monitor: every O_DONE pulse consumes the oldest expected job.
    always @(negedge I_CLK) begin
        if (I_ASYN_RSTN && O_DONE != '0) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_done", 64'(O_DONE), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("done_owner", 64'(O_DONE), 64'(N_REQ'(1) << mon_e.id));
                check_output("gnt_at_done", 64'(O_GNT), 64'(N_REQ'(1) << mon_e.id));
                check_output("err_at_done", 64'(O_ERR), 64'd0);
                check_wide("result", O_RESULT, mon_e.res);
            end
        end
    end

    task automatic apply_stimulus(input logic [N_REQ-1:0] mask);
        I_REQ = mask;
        @(negedge I_CLK);
        I_REQ = '0;
    endtask

    task automatic run_job(input int id, input int extra_pulses, input bit repulse, output int wait_cyc);
        logic [N_REQ-1:0] m;
        int n;
        m = N_REQ'(1) << id;
        wait_cyc = 0;
        do begin
            @(negedge I_CLK);
            wait_cyc++;
        end while (O_GNT == '0 && wait_cyc < 100);
        check_output("grant_id", 64'(O_GNT), 64'(m));
        @(negedge I_CLK);
        check_output("clear_phase", 64'({O_SA_CLEARN, O_SA_START}), 64'b00);
        @(negedge I_CLK);
        check_output("start_phase", 64'({O_SA_CLEARN, O_SA_START}), 64'b11);
        @(negedge I_CLK);
        check_output("start_len", 64'(O_SA_START), 64'd0);
        check_output("pe_shift", 64'(O_PE_SHIFT), 64'(m));
        check_wide("mat1_route", O_MAT_1, op1(id));
        check_wide("mat2_route", O_MAT_2, op2(id));
        for (int p = 0; p < extra_pulses; p++) begin
            if (p == 0) expect_job(id);
            apply_stimulus(m);
            @(negedge I_CLK);
        end
        n = 0;
        while (!I_SA_VLD && n < 200) begin
            @(negedge I_CLK);
            n++;
        end
        if (n >= 200) check_output("sa_vld_timeout", 64'd0, 64'd1);
        @(negedge I_CLK);
        check_output("done_latency", 64'(O_DONE), 64'(m));
        if (repulse) begin
            I_REQ = m;
            expect_job(id);
        end
        @(negedge I_CLK);
        I_REQ = '0;
        check_output("gnt_drop", 64'(O_GNT), 64'd0);
        check_wide("mat_idle", O_MAT_1, '0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int w;
        logic [M-1:0] res_before;
        I_ASYN_RSTN = 1'b0;
        I_SYNC_RSTN = 1'b1;
        I_REQ       = '0;
        spur_vld    = 1'b0;
        stub_dead   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            I_MAT_1[i*M +: M] = op1(i);
            I_MAT_2[i*M +: M] = op2(i);
        end
        repeat (2) @(negedge I_CLK);
        check_output("rst_gnt", 64'(O_GNT), 64'd0);
        check_output("rst_done_err", 64'({O_DONE, O_ERR}), 64'd0);
        check_output("rst_start_clearn", 64'({O_SA_START, O_SA_CLEARN}), 64'b01);
        check_wide("rst_result", O_RESULT, '0);
        I_ASYN_RSTN = 1'b1;
        @(negedge I_CLK);

        $display("[TB] single job");
        expect_job(0);
        apply_stimulus(4'b0001);
        run_job(0, 0, 1'b0, w);
        check_output("grant_latency", 64'(w), 64'd1);

        $display("[TB] stray SA valid while idle");
        spur_vld = 1'b1;
        @(negedge I_CLK);
        spur_vld = 1'b0;
        repeat (2) @(negedge I_CLK);
        check_wide("result_hold", O_RESULT, golden(0));
        check_output("stray_gnt", 64'(O_GNT), 64'd0);

        $display("[TB] synchronous clear");
        I_SYNC_RSTN = 1'b0;
        @(negedge I_CLK);
        I_SYNC_RSTN = 1'b1;
        check_wide("sync_rst_result", O_RESULT, '0);

        $display("[TB] simultaneous requests");
        for (int i = 0; i < N_REQ; i++) expect_job(i);
        apply_stimulus(4'b1111);
        for (int i = 0; i < N_REQ; i++) run_job(i, 0, 1'b0, w);

        $display("[TB] fairness 1/3");
        expect_job(1);
        expect_job(3);
        apply_stimulus(4'b1010);
        for (int k = 0; k < 8; k++) run_job((k % 2 == 0) ? 1 : 3, 0, k < 6, w);

        $display("[TB] re-request while served");
        expect_job(2);
        apply_stimulus(4'b0100);
        run_job(2, 2, 1'b0, w);
        run_job(2, 0, 1'b0, w);
        repeat (10) @(negedge I_CLK);
        check_output("no_extra_job", 64'(O_GNT), 64'd0);
        check_output("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] async reset mid-busy");
        apply_stimulus(4'b0001);
        repeat (8) @(negedge I_CLK);
        I_ASYN_RSTN = 1'b0;
        @(negedge I_CLK);
        check_output("abort_gnt", 64'(O_GNT), 64'd0);
        check_output("abort_done", 64'(O_DONE), 64'd0);
        check_output("abort_start_clearn", 64'({O_SA_START, O_SA_CLEARN}), 64'b01);
        check_wide("abort_result", O_RESULT, '0);
        @(negedge I_CLK);
        I_ASYN_RSTN = 1'b1;
        repeat (30) @(negedge I_CLK);
        check_output("abort_no_regrant", 64'(O_GNT), 64'd0);
        expect_job(0);
        apply_stimulus(4'b0001);
        run_job(0, 0, 1'b0, w);

`ifdef SA_ARB_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        stub_dead  = 1'b1;
        res_before = O_RESULT;
        apply_stimulus(4'b0001);
        w = 0;
        do begin
            @(negedge I_CLK);
            w++;
        end while (O_GNT == '0 && w < 100);
        repeat (2) @(negedge I_CLK);
        w = 0;
        while (O_ERR == '0 && w < 200) begin
            @(negedge I_CLK);
            w++;
        end
        check_output("timeout_cycles", 64'(w), 64'(TIMEOUT_CYC));
        check_output("timeout_err", 64'(O_ERR), 64'b0001);
        @(negedge I_CLK);
        check_output("timeout_clearn", 64'({O_SA_CLEARN, O_ERR}), 64'd0);
        check_output("timeout_gnt", 64'(O_GNT), 64'd0);
        @(negedge I_CLK);
        check_output("timeout_idle", 64'({O_SA_CLEARN, O_GNT}), 64'h10);
        check_wide("timeout_result", O_RESULT, res_before);
        stub_dead = 1'b0;
`else
        res_before = O_RESULT;
        check_wide("final_result", res_before, golden(0));
`endif

        repeat (5) @(negedge I_CLK);
        check_output("final_queue", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
